serv_mem_responder: RTL and testbench

- Wishbone-style responder that terminates the SERV core's instruction bus and data bus.
- Arbitrates between the two buses and serves both from one single-port synchronous SRAM macro.
- Generates the single-cycle ack pulses the core expects and can insert programmable wait states.
- Sits between the core top level and the on-chip SRAM in the gf180 SoC.

---
 rtl/serv_mem_responder_if.sv | 36 +++
 rtl/serv_mem_responder.sv | 194 +++++++++++++++++++
 tb/tb_serv_mem_responder.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/serv_mem_responder_if.sv
// rtl/serv_mem_responder_if.sv - SERV ibus/dbus and SRAM signal bundle for serv_mem_responder
interface serv_mem_responder_if #(
    parameter int MEM_AW = 10
);
    logic [31:0]       i_ibus_adr;
    logic              i_ibus_cyc;
    logic [31:0]       o_ibus_rdt;
    logic              o_ibus_ack;
    logic [31:0]       i_dbus_adr;
    logic [31:0]       i_dbus_dat;
    logic [3:0]        i_dbus_sel;
    logic              i_dbus_we;
    logic              i_dbus_cyc;
    logic [31:0]       o_dbus_rdt;
    logic              o_dbus_ack;
    logic [MEM_AW-1:0] o_mem_adr;
    logic              o_mem_en;
    logic [3:0]        o_mem_wen;
    logic [31:0]       o_mem_wdata;
    logic [31:0]       i_mem_rdata;
    logic              o_err;

    modport slave (
        input  i_ibus_adr, i_ibus_cyc, i_dbus_adr, i_dbus_dat, i_dbus_sel,
        input  i_dbus_we, i_dbus_cyc, i_mem_rdata,
        output o_ibus_rdt, o_ibus_ack, o_dbus_rdt, o_dbus_ack,
        output o_mem_adr, o_mem_en, o_mem_wen, o_mem_wdata, o_err
    );

    modport master (
        output i_ibus_adr, i_ibus_cyc, i_dbus_adr, i_dbus_dat, i_dbus_sel,
        output i_dbus_we, i_dbus_cyc, i_mem_rdata,
        input  o_ibus_rdt, o_ibus_ack, o_dbus_rdt, o_dbus_ack,
        input  o_mem_adr, o_mem_en, o_mem_wen, o_mem_wdata, o_err
    );
endinterface

// File: rtl/serv_mem_responder.sv
// rtl/serv_mem_responder.sv - round-robin SERV ibus/dbus responder on one single-port SRAM
// Optional address window check and sticky o_err: SERV_MEM_RESPONDER_RANGE_CHK_EN
module serv_mem_responder #(
    parameter int          MEM_AW      = 10,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic                  clk,
    input logic                  i_rst,
    serv_mem_responder_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_CAPTURE,
        S_ACK
    } state_t;

    localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t            state_q, state_d;
    logic              gnt_dbus_q, gnt_dbus_d;
    logic              last_dbus_q, last_dbus_d;
    logic              we_q, we_d;
    logic              oor_q, oor_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic              blank_i_q, blank_i_d;
    logic              blank_d_q, blank_d_d;
    logic              ibus_ack_q, ibus_ack_d;
    logic              dbus_ack_q, dbus_ack_d;
    logic [31:0]       ibus_rdt_q, ibus_rdt_d;
    logic [31:0]       dbus_rdt_q, dbus_rdt_d;
    logic [MEM_AW-1:0] mem_adr_q, mem_adr_d;
    logic              mem_en_q, mem_en_d;
    logic [3:0]        mem_wen_q, mem_wen_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic        ibus_pend, dbus_pend, pick_dbus, in_rng;
    logic [31:0] win_adr;
    logic        unused_adr_bits;

    // The core keeps cyc high one cycle past its ack, so that cycle is ignored.
    assign ibus_pend = bus.i_ibus_cyc && !blank_i_q;
    assign dbus_pend = bus.i_dbus_cyc && !blank_d_q;
    assign pick_dbus = dbus_pend && (!ibus_pend || !last_dbus_q);
    assign win_adr   = pick_dbus ? bus.i_dbus_adr : bus.i_ibus_adr;
    assign unused_adr_bits = ^win_adr;

`ifdef SERV_MEM_RESPONDER_RANGE_CHK_EN
    logic [31:0] win_off;
    always_comb begin
        win_off = win_adr - BASE_ADDR;
        in_rng  = (win_adr >= BASE_ADDR) && ((win_off >> (MEM_AW + 2)) == 32'd0);
    end
`else
    assign in_rng = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        gnt_dbus_d  = gnt_dbus_q;
        last_dbus_d = last_dbus_q;
        we_d        = we_q;
        oor_d       = oor_q;
        wcnt_d      = wcnt_q;
        blank_i_d   = ibus_ack_q;
        blank_d_d   = dbus_ack_q;
        ibus_ack_d  = 1'b0;
        dbus_ack_d  = 1'b0;
        ibus_rdt_d  = ibus_rdt_q;
        dbus_rdt_d  = dbus_rdt_q;
        mem_adr_d   = mem_adr_q;
        mem_en_d    = mem_en_q;
        mem_wen_d   = mem_wen_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (ibus_pend || dbus_pend) begin
                    state_d    = S_ACCESS;
                    gnt_dbus_d = pick_dbus;
                    we_d       = pick_dbus && bus.i_dbus_we;
                    oor_d      = !in_rng;
                    mem_adr_d  = win_adr[MEM_AW+1:2];
                    mem_en_d   = in_rng;
                    mem_wen_d  = (pick_dbus && bus.i_dbus_we && in_rng) ? bus.i_dbus_sel : 4'b0000;
                    if (pick_dbus && bus.i_dbus_we) begin
                        mem_wdata_d = bus.i_dbus_dat;
                    end
                end
            end
            S_ACCESS: begin
                mem_en_d  = 1'b0;
                mem_wen_d = 4'b0000;
                if (WAIT_STATES > 0) begin
                    state_d = S_WAIT;
                    wcnt_d  = WS_INIT;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_WAIT: begin
                if (wcnt_q == 4'd0) begin
                    state_d = S_CAPTURE;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            S_CAPTURE: begin
                // Read data lands in rdt together with the ack edge.
                state_d = S_ACK;
                if (gnt_dbus_q) begin
                    dbus_ack_d = 1'b1;
                    if (!we_q) begin
                        dbus_rdt_d = oor_q ? 32'h0 : bus.i_mem_rdata;
                    end
                end else begin
                    ibus_ack_d = 1'b1;
                    ibus_rdt_d = oor_q ? 32'h0 : bus.i_mem_rdata;
                end
            end
            S_ACK: begin
                last_dbus_d = gnt_dbus_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            gnt_dbus_q  <= 1'b0;
            last_dbus_q <= 1'b0;
            we_q        <= 1'b0;
            oor_q       <= 1'b0;
            wcnt_q      <= 4'd0;
            blank_i_q   <= 1'b0;
            blank_d_q   <= 1'b0;
            ibus_ack_q  <= 1'b0;
            dbus_ack_q  <= 1'b0;
            ibus_rdt_q  <= 32'h0;
            dbus_rdt_q  <= 32'h0;
            mem_adr_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_wen_q   <= 4'b0000;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            gnt_dbus_q  <= gnt_dbus_d;
            last_dbus_q <= last_dbus_d;
            we_q        <= we_d;
            oor_q       <= oor_d;
            wcnt_q      <= wcnt_d;
            blank_i_q   <= blank_i_d;
            blank_d_q   <= blank_d_d;
            ibus_ack_q  <= ibus_ack_d;
            dbus_ack_q  <= dbus_ack_d;
            ibus_rdt_q  <= ibus_rdt_d;
            dbus_rdt_q  <= dbus_rdt_d;
            mem_adr_q   <= mem_adr_d;
            mem_en_q    <= mem_en_d;
            mem_wen_q   <= mem_wen_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifdef SERV_MEM_RESPONDER_RANGE_CHK_EN
    logic err_q, err_d;
    always_comb begin
        err_d = err_q | ((state_q == S_CAPTURE) && oor_q);
    end
    always_ff @(posedge clk) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign bus.o_err = err_q;
`else
    assign bus.o_err = 1'b0;
`endif

    assign bus.o_ibus_ack  = ibus_ack_q;
    assign bus.o_dbus_ack  = dbus_ack_q;
    assign bus.o_ibus_rdt  = ibus_rdt_q;
    assign bus.o_dbus_rdt  = dbus_rdt_q;
    assign bus.o_mem_adr   = mem_adr_q;
    assign bus.o_mem_en    = mem_en_q;
    assign bus.o_mem_wen   = mem_wen_q;
    assign bus.o_mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_serv_mem_responder.sv
// tb/tb_serv_mem_responder.sv - directed bench for serv_mem_responder (WAIT_STATES 0 and 3 instances)
module tb_serv_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serv_mem_responder_if #(.MEM_AW(10)) b0 ();
    serv_mem_responder_if #(.MEM_AW(10)) b3 ();

    serv_mem_responder #(.MEM_AW(10), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_dut0 (
        .clk(clk), .i_rst(rst), .bus(b0.slave)
    );
    serv_mem_responder #(.MEM_AW(10), .WAIT_STATES(3), .BASE_ADDR(32'h0)) u_dut3 (
        .clk(clk), .i_rst(rst), .bus(b3.slave)
    );

    logic [31:0] mem0 [0:1023];
    logic [31:0] mem3 [0:1023];

    // SRAM models: preset words on reset, read-before-write, data valid one cycle after en.
    always @(posedge clk) begin
        if (rst) begin
            mem0[0] <= 32'h55AA_55AA;
            mem0[2] <= 32'hAABB_CCDD;
            mem0[3] <= 32'h0BAD_F00D;
            mem0[4] <= 32'h1234_5678;
            mem0[5] <= 32'hDEAD_BEEF;
            b0.i_mem_rdata <= 32'h0;
        end else if (b0.o_mem_en) begin
            b0.i_mem_rdata <= mem0[b0.o_mem_adr];
            for (int b = 0; b < 4; b++)
                if (b0.o_mem_wen[b]) mem0[b0.o_mem_adr][8*b +: 8] <= b0.o_mem_wdata[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            mem3[7] <= 32'hCAFE_F00D;
            b3.i_mem_rdata <= 32'h0;
        end else if (b3.o_mem_en) begin
            b3.i_mem_rdata <= mem3[b3.o_mem_adr];
            for (int b = 0; b < 4; b++)
                if (b3.o_mem_wen[b]) mem3[b3.o_mem_adr][8*b +: 8] <= b3.o_mem_wdata[8*b +: 8];
        end
    end

    int viol = 0, iack0 = 0, dack0 = 0, dack3 = 0;
    logic prev0 = 1'b0, prev3 = 1'b0;
    always @(negedge clk) begin
        if (b0.o_ibus_ack && b0.o_dbus_ack) viol++;
        if ((b0.o_ibus_ack || b0.o_dbus_ack) && prev0) viol++;
        if (b3.o_ibus_ack && b3.o_dbus_ack) viol++;
        if ((b3.o_ibus_ack || b3.o_dbus_ack) && prev3) viol++;
        prev0 = b0.o_ibus_ack || b0.o_dbus_ack;
        prev3 = b3.o_ibus_ack || b3.o_dbus_ack;
        if (b0.o_ibus_ack) iack0++;
        if (b0.o_dbus_ack) dack0++;
        if (b3.o_dbus_ack) dack3++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int snap;

    initial begin
        b0.i_ibus_adr = 0; b0.i_ibus_cyc = 0; b0.i_dbus_adr = 0; b0.i_dbus_dat = 0;
        b0.i_dbus_sel = 0; b0.i_dbus_we = 0; b0.i_dbus_cyc = 0;
        b3.i_ibus_adr = 0; b3.i_ibus_cyc = 0; b3.i_dbus_adr = 0; b3.i_dbus_dat = 0;
        b3.i_dbus_sel = 0; b3.i_dbus_we = 0; b3.i_dbus_cyc = 0;
        rst = 1'b1;
        tick(2);
        check("rst_ibus_ack", 32'(b0.o_ibus_ack), 32'd0);
        check("rst_dbus_ack", 32'(b0.o_dbus_ack), 32'd0);
        check("rst_mem_en", 32'(b0.o_mem_en), 32'd0);
        check("rst_mem_wen", 32'(b0.o_mem_wen), 32'd0);
        check("rst_ibus_rdt", b0.o_ibus_rdt, 32'h0);
        check("rst_dbus_rdt", b0.o_dbus_rdt, 32'h0);
        check("rst_err", 32'(b0.o_err), 32'd0);
        rst = 1'b0;
        tick(1);

        // ibus read of word 5
        snap = iack0;
        b0.i_ibus_adr = 32'h14; b0.i_ibus_cyc = 1'b1;
        tick(1);
        check("t1_mem_en", 32'(b0.o_mem_en), 32'd1);
        check("t1_mem_adr", 32'(b0.o_mem_adr), 32'd5);
        check("t1_mem_wen", 32'(b0.o_mem_wen), 32'd0);
        tick(1);
        check("t1_ack_c2", 32'(b0.o_ibus_ack), 32'd0);
        tick(1);
        check("t1_ack_c3", 32'(b0.o_ibus_ack), 32'd1);
        check("t1_rdt", b0.o_ibus_rdt, 32'hDEAD_BEEF);
        tick(1);
        check("t1_ack_c4", 32'(b0.o_ibus_ack), 32'd0);
        b0.i_ibus_cyc = 1'b0;
        tick(3);
        check("t1_one_ack", 32'(iack0 - snap), 32'd1);

        // both buses at once, last grant was ibus -> dbus first
        b0.i_ibus_adr = 32'h0C; b0.i_ibus_cyc = 1'b1;
        b0.i_dbus_adr = 32'h08; b0.i_dbus_we = 1'b0; b0.i_dbus_cyc = 1'b1;
        tick(1);
        check("t3_first_adr", 32'(b0.o_mem_adr), 32'd2);
        tick(2);
        check("t3_dack_c3", 32'(b0.o_dbus_ack), 32'd1);
        check("t3_iack_c3", 32'(b0.o_ibus_ack), 32'd0);
        check("t3_drdt", b0.o_dbus_rdt, 32'hAABB_CCDD);
        tick(1);
        check("t3_dack_c4", 32'(b0.o_dbus_ack), 32'd0);
        b0.i_dbus_cyc = 1'b0;
        tick(1);
        check("t3_second_adr", 32'(b0.o_mem_adr), 32'd3);
        check("t3_second_en", 32'(b0.o_mem_en), 32'd1);
        tick(2);
        check("t3_iack_c7", 32'(b0.o_ibus_ack), 32'd1);
        check("t3_dack_c7", 32'(b0.o_dbus_ack), 32'd0);
        check("t3_irdt", b0.o_ibus_rdt, 32'h0BAD_F00D);
        tick(1);
        check("t3_iack_c8", 32'(b0.o_ibus_ack), 32'd0);
        b0.i_ibus_cyc = 1'b0;
        tick(2);

        // dbus byte write then read back
        b0.i_dbus_adr = 32'h08; b0.i_dbus_dat = 32'h1122_3344; b0.i_dbus_sel = 4'b0100;
        b0.i_dbus_we = 1'b1; b0.i_dbus_cyc = 1'b1;
        tick(1);
        check("t2_wen", 32'(b0.o_mem_wen), 32'h4);
        check("t2_wdata", b0.o_mem_wdata, 32'h1122_3344);
        check("t2_wadr", 32'(b0.o_mem_adr), 32'd2);
        tick(2);
        check("t2_wack", 32'(b0.o_dbus_ack), 32'd1);
        check("t2_rdt_hold", b0.o_dbus_rdt, 32'hAABB_CCDD);
        tick(1);
        b0.i_dbus_cyc = 1'b0; b0.i_dbus_we = 1'b0;
        tick(1);
        b0.i_dbus_cyc = 1'b1;
        tick(1);
        check("t2_rd_wen", 32'(b0.o_mem_wen), 32'd0);
        tick(2);
        check("t2_rack", 32'(b0.o_dbus_ack), 32'd1);
        check("t2_rdata", b0.o_dbus_rdt, 32'hAA22_CCDD);
        tick(1);
        b0.i_dbus_cyc = 1'b0;
        tick(2);

        // reset in the cycle after ACCESS abandons the read
        b0.i_dbus_adr = 32'h10; b0.i_dbus_cyc = 1'b1;
        tick(1);
        check("t5_mem_en", 32'(b0.o_mem_en), 32'd1);
        tick(1);
        rst = 1'b1; b0.i_dbus_cyc = 1'b0;
        tick(1);
        rst = 1'b0;
        check("t5_dack_c3", 32'(b0.o_dbus_ack), 32'd0);
        check("t5_iack_c3", 32'(b0.o_ibus_ack), 32'd0);
        check("t5_en_c3", 32'(b0.o_mem_en), 32'd0);
        check("t5_rdt_c3", b0.o_dbus_rdt, 32'h0);
        tick(1);
        check("t5_dack_c4", 32'(b0.o_dbus_ack), 32'd0);
        tick(1);
        b0.i_dbus_cyc = 1'b1;
        tick(3);
        check("t5_fresh_ack", 32'(b0.o_dbus_ack), 32'd1);
        check("t5_fresh_rdt", b0.o_dbus_rdt, 32'h1234_5678);
        tick(1);
        b0.i_dbus_cyc = 1'b0;
        tick(2);

        // three wait states
        snap = dack3;
        b3.i_dbus_adr = 32'h1C; b3.i_dbus_cyc = 1'b1;
        tick(1);
        check("ws3_en_c1", 32'(b3.o_mem_en), 32'd1);
        tick(1);
        check("ws3_en_c2", 32'(b3.o_mem_en), 32'd0);
        tick(3);
        check("ws3_ack_c5", 32'(b3.o_dbus_ack), 32'd0);
        tick(1);
        check("ws3_ack_c6", 32'(b3.o_dbus_ack), 32'd1);
        check("ws3_rdt", b3.o_dbus_rdt, 32'hCAFE_F00D);
        tick(1);
        check("ws3_ack_c7", 32'(b3.o_dbus_ack), 32'd0);
        b3.i_dbus_cyc = 1'b0;
        tick(4);
        check("ws3_one_ack", 32'(dack3 - snap), 32'd1);

        // address 0x1000 lies one window above the 4 KiB SRAM
        b0.i_dbus_adr = 32'h1000; b0.i_dbus_cyc = 1'b1;
        tick(1);
`ifdef SERV_MEM_RESPONDER_RANGE_CHK_EN
        check("oor_en", 32'(b0.o_mem_en), 32'd0);
        tick(2);
        check("oor_ack", 32'(b0.o_dbus_ack), 32'd1);
        check("oor_rdt", b0.o_dbus_rdt, 32'h0);
        check("oor_err", 32'(b0.o_err), 32'd1);
        tick(1);
        b0.i_dbus_cyc = 1'b0;
        tick(4);
        check("oor_err_sticky", 32'(b0.o_err), 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("oor_err_cleared", 32'(b0.o_err), 32'd0);
`else
        check("alias_en", 32'(b0.o_mem_en), 32'd1);
        check("alias_adr", 32'(b0.o_mem_adr), 32'd0);
        tick(2);
        check("alias_ack", 32'(b0.o_dbus_ack), 32'd1);
        check("alias_rdt", b0.o_dbus_rdt, 32'h55AA_55AA);
        check("alias_err", 32'(b0.o_err), 32'd0);
        tick(1);
        b0.i_dbus_cyc = 1'b0;
        tick(2);
`endif
        tick(1);
        check("ack_overlap_or_repeat", 32'(viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
